// File: rtl/video_pkg.sv
// Shared constants for the video capture path: control opcodes, colour modes,
// capture states and small packing helpers.
package video_pkg;

  localparam logic [7:0] OP_COLORMODE   = 8'd1;
  localparam logic [7:0] OP_DIMENSIONS  = 8'd2;
  localparam logic [7:0] OP_CAPTURE_EN  = 8'd6;
  localparam logic [7:0] OP_TESTPATTERN = 8'd7;

  localparam logic [1:0] CMODE_8BIT  = 2'd0;
  localparam logic [1:0] CMODE_16BIT = 2'd1;
  localparam logic [1:0] CMODE_32BIT = 2'd2;
  localparam logic [1:0] CMODE_15BIT = 2'd3;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACTIVE = 2'd1;
  localparam state_t ST_DROP   = 2'd2;
  localparam state_t ST_SKIP   = 2'd3;

  localparam logic [15:0] WIDTH_RESET = 16'd640;

  function automatic logic [15:0] swap16(input logic [15:0] p);
    return {p[7:0], p[15:8]};
  endfunction

  // Index of the lane that completes a word in the given colour mode.
  function automatic logic [1:0] last_lane(input logic [1:0] cmode);
    case (cmode)
      CMODE_8BIT:  return 2'd3;
      CMODE_16BIT: return 2'd1;
      CMODE_15BIT: return 2'd1;
      CMODE_32BIT: return 2'd0;
      default:     return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/video_capture_fifo.sv
// Synchronous output FIFO holding {tuser, tlast, data} beats; data reads as
// zero while empty so the stream outputs are clean out of reset.
module video_capture_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_rd_s;

  assign do_rd_s = rd_en && !empty;
  assign empty   = (count_r == '0);
  assign full    = (count_r == FULL_COUNT);
  assign rd_data = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

  // Storage array, written on every accepted push.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_rd_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({wr_en, do_rd_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/video_capture_packer.sv
// Packs captured pixels into 32-bit AXI-stream beats for VDMA S2MM.
// Optional internal test pattern source: define VIDEO_CAPTURE_TESTPATTERN_EN.
module video_capture_packer
  import video_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        m_axis_vid_aclk,
  input  logic        aresetn,
  input  logic [31:0] pix_data,
  input  logic        pix_valid,
  input  logic        pix_sof,
  input  logic        pix_eol,
  output logic [31:0] m_axis_vid_tdata,
  output logic        m_axis_vid_tvalid,
  input  logic        m_axis_vid_tready,
  output logic        m_axis_vid_tuser,
  output logic        m_axis_vid_tlast,
  input  logic [31:0] control_data,
  input  logic [7:0]  control_op,
  output logic        overflow,
  output logic [15:0] frames_dropped,
  output logic [1:0]  dbg_state
);

  logic [7:0]  ctrl_op_r;
  logic [31:0] ctrl_data_r;
  logic [1:0]  colormode_r;
  logic [15:0] width_r;
  logic        enable_r;
  state_t      state_r;
  logic [31:0] acc_r;
  logic [1:0]  idx_r;
  logic [15:0] cnt_r;
  logic        first_r;
  logic        push_valid_r;
  logic [33:0] push_word_r;
  logic        overflow_r;
  logic [15:0] frames_dropped_r;

  logic [31:0] src_data_s;
  logic        src_valid_s, src_sof_s, src_eol_s;
  logic [31:0] base_acc_s, lane_word_s;
  logic [1:0]  base_idx_s;
  logic [15:0] base_cnt_s, cnt_next_s;
  logic        base_first_s, width_hit_s, word_done_s, take_s;
  logic        pop_s, drop_s, push_s;
  logic [33:0] fifo_rd_s;
  logic        fifo_empty_s, fifo_full_s;
  logic        unused_ctrl_s;

  assign unused_ctrl_s = &{1'b0, ctrl_data_r[31:16]};

`ifdef VIDEO_CAPTURE_TESTPATTERN_EN
  logic        tp_en_r;
  logic [15:0] tp_x_r;
  logic [8:0]  tp_y_r;

  // Pattern raster: x runs 0..width-1, a frame is 480 lines.
  always_ff @(posedge m_axis_vid_aclk) begin
    if (!aresetn || !tp_en_r) begin
      tp_x_r <= 16'd0;
      tp_y_r <= 9'd0;
    end else if (tp_x_r == width_r - 16'd1) begin
      tp_x_r <= 16'd0;
      tp_y_r <= (tp_y_r == 9'd479) ? 9'd0 : tp_y_r + 9'd1;
    end else begin
      tp_x_r <= tp_x_r + 16'd1;
    end
  end

  assign src_data_s  = tp_en_r ? {16'd0, tp_x_r} : pix_data;
  assign src_valid_s = tp_en_r ? 1'b1 : pix_valid;
  assign src_sof_s   = tp_en_r ? ((tp_x_r == 16'd0) && (tp_y_r == 9'd0)) : pix_sof;
  assign src_eol_s   = tp_en_r ? (tp_x_r == width_r - 16'd1) : pix_eol;
`else
  assign src_data_s  = pix_data;
  assign src_valid_s = pix_valid;
  assign src_sof_s   = pix_sof;
  assign src_eol_s   = pix_eol;
`endif

  // Control port: opcode and payload are registered, then decoded.
  always_ff @(posedge m_axis_vid_aclk) begin
    if (!aresetn) begin
      ctrl_op_r   <= 8'd0;
      ctrl_data_r <= 32'd0;
      colormode_r <= CMODE_16BIT;
      width_r     <= WIDTH_RESET;
      enable_r    <= 1'b0;
`ifdef VIDEO_CAPTURE_TESTPATTERN_EN
      tp_en_r     <= 1'b0;
`endif
    end else begin
      ctrl_op_r   <= control_op;
      ctrl_data_r <= control_data;
      case (ctrl_op_r)
        OP_COLORMODE:   colormode_r <= ctrl_data_r[1:0];
        OP_DIMENSIONS:  width_r     <= ctrl_data_r[15:0];
        OP_CAPTURE_EN:  enable_r    <= ctrl_data_r[0];
`ifdef VIDEO_CAPTURE_TESTPATTERN_EN
        OP_TESTPATTERN: tp_en_r     <= ctrl_data_r[0];
`endif
        default:        enable_r    <= enable_r;
      endcase
    end
  end

  // Lane placement of the incoming pixel; a sof pixel starts a fresh word.
  always_comb begin
    base_acc_s   = src_sof_s ? 32'd0 : acc_r;
    base_idx_s   = src_sof_s ? 2'd0  : idx_r;
    base_cnt_s   = src_sof_s ? 16'd0 : cnt_r;
    base_first_s = src_sof_s ? 1'b1  : first_r;
    lane_word_s  = base_acc_s;
    case (colormode_r)
      CMODE_8BIT: begin
        case (base_idx_s)
          2'd0:    lane_word_s[7:0]   = src_data_s[7:0];
          2'd1:    lane_word_s[15:8]  = src_data_s[7:0];
          2'd2:    lane_word_s[23:16] = src_data_s[7:0];
          default: lane_word_s[31:24] = src_data_s[7:0];
        endcase
      end
      CMODE_16BIT, CMODE_15BIT: begin
        if (base_idx_s[0]) begin
          lane_word_s[31:16] = swap16(src_data_s[15:0]);
        end else begin
          lane_word_s[15:0] = swap16(src_data_s[15:0]);
        end
      end
      default: lane_word_s = src_data_s;
    endcase
    cnt_next_s  = base_cnt_s + 16'd1;
    width_hit_s = (cnt_next_s == width_r) && !src_eol_s;
    word_done_s = (base_idx_s >= last_lane(colormode_r)) || src_eol_s || width_hit_s;
    take_s      = src_valid_s && ((src_sof_s && enable_r) || ((state_r == ST_ACTIVE) && !src_sof_s));
    pop_s       = !fifo_empty_s && m_axis_vid_tready;
    drop_s      = push_valid_r && fifo_full_s && !pop_s;
    push_s      = push_valid_r && !drop_s;
  end

  // Capture state, word assembly and the one-deep push stage.
  always_ff @(posedge m_axis_vid_aclk) begin
    if (!aresetn) begin
      state_r          <= ST_IDLE;
      acc_r            <= 32'd0;
      idx_r            <= 2'd0;
      cnt_r            <= 16'd0;
      first_r          <= 1'b0;
      push_valid_r     <= 1'b0;
      push_word_r      <= 34'd0;
      overflow_r       <= 1'b0;
      frames_dropped_r <= 16'd0;
    end else if (drop_s) begin
      // The word in the push stage is lost; the rest of the frame goes too.
      state_r          <= ST_DROP;
      acc_r            <= 32'd0;
      idx_r            <= 2'd0;
      cnt_r            <= 16'd0;
      first_r          <= 1'b0;
      push_valid_r     <= 1'b0;
      overflow_r       <= 1'b1;
      frames_dropped_r <= (frames_dropped_r == 16'hFFFF) ? 16'hFFFF : frames_dropped_r + 16'd1;
    end else if (take_s) begin
      if (word_done_s) begin
        push_valid_r <= 1'b1;
        push_word_r  <= {base_first_s, src_eol_s || width_hit_s, lane_word_s};
        acc_r        <= 32'd0;
        idx_r        <= 2'd0;
        first_r      <= 1'b0;
      end else begin
        push_valid_r <= 1'b0;
        acc_r        <= lane_word_s;
        idx_r        <= base_idx_s + 2'd1;
        first_r      <= base_first_s;
      end
      cnt_r   <= (src_eol_s || width_hit_s) ? 16'd0 : cnt_next_s;
      state_r <= width_hit_s ? ST_SKIP : ST_ACTIVE;
    end else if (src_valid_s && src_sof_s) begin
      state_r      <= ST_IDLE;
      acc_r        <= 32'd0;
      idx_r        <= 2'd0;
      cnt_r        <= 16'd0;
      first_r      <= 1'b0;
      push_valid_r <= 1'b0;
    end else begin
      push_valid_r <= 1'b0;
      if (src_valid_s && src_eol_s && (state_r == ST_SKIP)) begin
        state_r <= ST_ACTIVE;
      end
    end
  end

  video_capture_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (34)
  ) u_fifo (
    .clk     (m_axis_vid_aclk),
    .aresetn (aresetn),
    .wr_en   (push_s),
    .wr_data (push_word_r),
    .rd_en   (pop_s),
    .rd_data (fifo_rd_s),
    .empty   (fifo_empty_s),
    .full    (fifo_full_s)
  );

  assign m_axis_vid_tvalid = !fifo_empty_s;
  assign m_axis_vid_tdata  = fifo_rd_s[31:0];
  assign m_axis_vid_tuser  = fifo_rd_s[33];
  assign m_axis_vid_tlast  = fifo_rd_s[32];
  assign overflow          = overflow_r;
  assign frames_dropped    = frames_dropped_r;
  assign dbg_state         = state_r;

endmodule

// File: tb/tb_video_capture_packer.sv
// Scoreboard bench for video_capture_packer: expected beats are queued with
// the stimulus and a forked monitor compares every accepted output beat.
module tb_video_capture_packer;

  logic        clk;
  logic        aresetn;
  logic [31:0] pix_data;
  logic        pix_valid, pix_sof, pix_eol;
  logic [31:0] tdata;
  logic        tvalid, tready, tuser, tlast;
  logic [31:0] control_data;
  logic [7:0]  control_op;
  logic        overflow;
  logic [15:0] frames_dropped;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  logic [33:0] exp_q[$];

  video_capture_packer #(.FIFO_DEPTH(16)) dut (
    .m_axis_vid_aclk   (clk),
    .aresetn           (aresetn),
    .pix_data          (pix_data),
    .pix_valid         (pix_valid),
    .pix_sof           (pix_sof),
    .pix_eol           (pix_eol),
    .m_axis_vid_tdata  (tdata),
    .m_axis_vid_tvalid (tvalid),
    .m_axis_vid_tready (tready),
    .m_axis_vid_tuser  (tuser),
    .m_axis_vid_tlast  (tlast),
    .control_data      (control_data),
    .control_op        (control_op),
    .overflow          (overflow),
    .frames_dropped    (frames_dropped),
    .dbg_state         (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, want);
    end
  endtask

  task automatic expect_beat(input logic u, input logic l, input logic [31:0] d);
    exp_q.push_back({u, l, d});
  endtask

  task automatic px(input logic [31:0] d, input logic s, input logic e);
    pix_data  = d;
    pix_valid = 1'b1;
    pix_sof   = s;
    pix_eol   = e;
    tick();
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_eol   = 1'b0;
  endtask

  task automatic ctrl(input logic [7:0] op, input logic [31:0] d);
    control_op   = op;
    control_data = d;
    tick();
    control_op   = 8'd0;
    control_data = 32'd0;
    tick();
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      tick();
    end
    chk("drain_left", exp_q.size(), 32'd0);
    repeat (4) tick();
  endtask

  // Beat monitor: sampled on the falling edge, a beat is accepted at the next rise.
  task automatic monitor();
    logic [33:0] e;
    forever begin
      @(negedge clk);
      if (aresetn && tvalid && tready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL beat_unexpected got=%0h want=none", {tuser, tlast, tdata});
        end else begin
          e = exp_q.pop_front();
          if ({tuser, tlast, tdata} !== e) begin
            bad++;
            $display("FAIL beat got=%0h want=%0h", {tuser, tlast, tdata}, e);
          end
        end
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    aresetn = 1'b0; tready = 1'b1;
    pix_data = 32'd0; pix_valid = 1'b0; pix_sof = 1'b0; pix_eol = 1'b0;
    control_data = 32'd0; control_op = 8'd0;
    repeat (3) tick();
    chk("rst_tvalid", {31'd0, tvalid}, 32'd0);
    chk("rst_tdata", tdata, 32'd0);
    chk("rst_tuser_tlast", {30'd0, tuser, tlast}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_dropped", {16'd0, frames_dropped}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    aresetn = 1'b1;
    tick();

    // Capture disabled out of reset: a full frame is ignored.
    px(32'h5, 1'b1, 1'b1);
    repeat (4) tick();
    chk("idle_disabled", {30'd0, dbg_state}, 32'd0);

    ctrl(8'd6, 32'd1);
    ctrl(8'd1, 32'd2);
    ctrl(8'd2, 32'd4);

    // 32-bit line of four pixels, plus two-cycle latency on the first.
    expect_beat(1'b1, 1'b0, 32'd1);
    expect_beat(1'b0, 1'b0, 32'd2);
    expect_beat(1'b0, 1'b0, 32'd3);
    expect_beat(1'b0, 1'b1, 32'd4);
    px(32'd1, 1'b1, 1'b0);
    chk("lat_n1", {31'd0, tvalid}, 32'd0);
    px(32'd2, 1'b0, 1'b0);
    chk("lat_n2", {31'd0, tvalid}, 32'd1);
    px(32'd3, 1'b0, 1'b0);
    px(32'd4, 1'b0, 1'b1);
    drain();

    // sof and eol on one pixel.
    expect_beat(1'b1, 1'b1, 32'h0ABC);
    px(32'h0ABC, 1'b1, 1'b1);
    drain();

    // 8-bit, width 6: full word then zero-padded tail.
    ctrl(8'd1, 32'd0);
    ctrl(8'd2, 32'd6);
    expect_beat(1'b1, 1'b0, 32'h44332211);
    expect_beat(1'b0, 1'b1, 32'h00006655);
    px(32'h11, 1'b1, 1'b0);
    px(32'h22, 1'b0, 1'b0);
    px(32'h33, 1'b0, 1'b0);
    px(32'h44, 1'b0, 1'b0);
    px(32'h55, 1'b0, 1'b0);
    px(32'h66, 1'b0, 1'b1);
    drain();

    // New sof mid-word discards the partial word.
    expect_beat(1'b1, 1'b1, 32'h04030201);
    px(32'hAA, 1'b1, 1'b0);
    px(32'hBB, 1'b0, 1'b0);
    px(32'h01, 1'b1, 1'b0);
    px(32'h02, 1'b0, 1'b0);
    px(32'h03, 1'b0, 1'b0);
    px(32'h04, 1'b0, 1'b1);
    drain();

    // 16-bit byte-swapped packing, then a short second line.
    ctrl(8'd1, 32'd1);
    expect_beat(1'b1, 1'b1, 32'hD4C3B2A1);
    expect_beat(1'b0, 1'b0, 32'h04030201);
    expect_beat(1'b0, 1'b1, 32'h00000605);
    px(32'hA1B2, 1'b1, 1'b0);
    px(32'hC3D4, 1'b0, 1'b1);
    px(32'h0102, 1'b0, 1'b0);
    px(32'h0304, 1'b0, 1'b0);
    px(32'h0506, 1'b0, 1'b1);
    drain();

    // Line longer than width: forced tlast, skip to eol, next line resumes.
    ctrl(8'd1, 32'd2);
    ctrl(8'd2, 32'd4);
    expect_beat(1'b1, 1'b0, 32'h10);
    expect_beat(1'b0, 1'b0, 32'h11);
    expect_beat(1'b0, 1'b0, 32'h12);
    expect_beat(1'b0, 1'b1, 32'h13);
    px(32'h10, 1'b1, 1'b0);
    px(32'h11, 1'b0, 1'b0);
    px(32'h12, 1'b0, 1'b0);
    px(32'h13, 1'b0, 1'b0);
    chk("skip_state", {30'd0, dbg_state}, 32'd3);
    px(32'h14, 1'b0, 1'b0);
    px(32'h15, 1'b0, 1'b0);
    px(32'h16, 1'b0, 1'b0);
    px(32'h17, 1'b0, 1'b1);
    chk("skip_exit", {30'd0, dbg_state}, 32'd1);
    expect_beat(1'b0, 1'b0, 32'h20);
    expect_beat(1'b0, 1'b1, 32'h21);
    px(32'h20, 1'b0, 1'b0);
    px(32'h21, 1'b0, 1'b1);
    drain();

    // Full FIFO with push and pop on the same edge: nothing lost.
    ctrl(8'd2, 32'd32);
    tready = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      expect_beat(i == 1, i == 18, 32'(i));
    end
    px(32'd1, 1'b1, 1'b0);
    for (int i = 2; i <= 17; i++) begin
      px(32'(i), 1'b0, 1'b0);
    end
    tready = 1'b1;
    px(32'd18, 1'b0, 1'b1);
    drain();
    chk("full_push_pop_ovf", {31'd0, overflow}, 32'd0);

    // Overrun with tready held low: 16 beats kept, rest of frame dropped.
    tready = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      expect_beat(i == 1, 1'b0, 32'(i));
    end
    px(32'd1, 1'b1, 1'b0);
    for (int i = 2; i <= 19; i++) begin
      px(32'(i), 1'b0, 1'b0);
    end
    px(32'd20, 1'b0, 1'b1);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    chk("ovf_dropped", {16'd0, frames_dropped}, 32'd1);
    chk("ovf_state", {30'd0, dbg_state}, 32'd2);
    px(32'h99, 1'b0, 1'b1);
    chk("drop_hold", {30'd0, dbg_state}, 32'd2);
    tready = 1'b1;
    drain();
    chk("drop_empty", {31'd0, tvalid}, 32'd0);
    expect_beat(1'b1, 1'b1, 32'h77);
    px(32'h77, 1'b1, 1'b1);
    drain();
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
    chk("dropped_once", {16'd0, frames_dropped}, 32'd1);

    // Reset mid-line flushes the FIFO; capture waits for the next sof.
    tready = 1'b0;
    px(32'h50, 1'b1, 1'b0);
    px(32'h51, 1'b0, 1'b0);
    px(32'h52, 1'b0, 1'b0);
    chk("pre_reset_valid", {31'd0, tvalid}, 32'd1);
    aresetn = 1'b0;
    tick();
    chk("reset_flush", {31'd0, tvalid}, 32'd0);
    chk("reset_tdata", tdata, 32'd0);
    chk("reset_overflow", {31'd0, overflow}, 32'd0);
    chk("reset_dropped", {16'd0, frames_dropped}, 32'd0);
    aresetn = 1'b1;
    tready  = 1'b1;
    tick();
    ctrl(8'd6, 32'd1);
    px(32'h61, 1'b0, 1'b1);
    chk("wait_sof", {30'd0, dbg_state}, 32'd0);
    // Colour mode is back at its 16-bit default.
    expect_beat(1'b1, 1'b1, 32'h78563412);
    px(32'h1234, 1'b1, 1'b0);
    px(32'h5678, 1'b0, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
